// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first payload, optional even parity, stop bit.
// Completed good frames are held in a single-entry output register with a valid/ready handshake.
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par;
    logic               w_par_ok;
    logic               w_good;

    // Handshake: data_out is offered while out_valid=1 and is consumed on any
    // edge where out_valid=1 and out_ready=1; out_ready is ignored otherwise.

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!data_in) w_next = S_DATA;
            S_DATA:   if (r_bit_cnt == LAST_BIT) w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // In S_STOP, data_in is the stop bit being sampled on this edge.
    assign w_par_ok = ~(^{r_shift, r_par});
    assign w_good   = data_in && ((PARITY_EN == 0) || w_par_ok);
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= '0;
                end
                S_DATA: begin
                    r_shift   <= {data_in, r_shift[DATA_W-1:1]};
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
                S_PARITY: begin
                    r_par <= data_in;
                end
                S_STOP: begin
                    if (!data_in) begin
                        frame_err <= 1'b1;
                    end else if (!w_good) begin
                        parity_err <= 1'b1;
                    end else if (!out_valid || out_ready) begin
                        data_out  <= r_shift;
                        out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=8, PARITY_EN=1): a vector table of
// whole frames plus hand-written sequences for handshake, back-to-back and reset corners.
module tb_serial_frame_rx;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic       out_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int checks;
    int failures;
    logic pre_valid;
    logic pre_busy;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       rdy;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_pe;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives start, 8 payload bits LSB first, parity, stop; returns #1 after the stop edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic rdy_body, input logic rdy_stop);
        out_ready = rdy_body;
        data_in   = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            data_in = d[i];
            step();
        end
        data_in = p;
        step();
        pre_valid = out_valid;
        pre_busy  = busy;
        out_ready = rdy_stop;
        data_in   = s;
        step();
        data_in = 1'b1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        data_in = 1'b1;
        step();
        rst = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        data_in   = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        chk("reset_data_out", 32'(data_out), 32'h00);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_errs", 32'({parity_err, frame_err}), 32'h0);
        rst = 1'b1;

        //          data    par   stop  rdy   e_v   e_d    e_pe  e_fe  e_ov
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].d, vecs[v].p, vecs[v].s, vecs[v].rdy, vecs[v].rdy);
            chk($sformatf("vec%0d_busy_before_stop", v), 32'(pre_busy), 32'h1);
            chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].e_v));
            chk($sformatf("vec%0d_data_out", v), 32'(data_out), 32'(vecs[v].e_d));
            chk($sformatf("vec%0d_parity_err", v), 32'(parity_err), 32'(vecs[v].e_pe));
            chk($sformatf("vec%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].e_fe));
            chk($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].e_ov));
            step();
            chk($sformatf("vec%0d_idle_busy", v), 32'(busy), 32'h0);
            chk($sformatf("vec%0d_idle_errs", v), 32'({parity_err, frame_err}), 32'h0);
            chk($sformatf("vec%0d_idle_valid", v), 32'(out_valid), 32'(vecs[v].e_v & ~vecs[v].rdy));
            chk($sformatf("vec%0d_idle_data", v), 32'(data_out), 32'(vecs[v].e_d));
        end

        // Latency: nothing visible after the parity edge, load on the stop edge.
        do_reset();
        chk("rst_clears_overrun", 32'(overrun), 32'h0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("lat_pre_valid", 32'(pre_valid), 32'h0);
        chk("lat_valid", 32'(out_valid), 32'h1);
        chk("lat_data", 32'(data_out), 32'hA5);

        // Back-to-back frames with consumer stalled: second good frame is an overrun.
        do_reset();
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_first_valid", 32'(out_valid), 32'h1);
        chk("b2b_first_data", 32'(data_out), 32'h3C);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_second_data", 32'(data_out), 32'h3C);
        chk("b2b_second_valid", 32'(out_valid), 32'h1);
        chk("b2b_overrun", 32'(overrun), 32'h1);
        out_ready = 1'b1;
        step();
        chk("b2b_consume_valid", 32'(out_valid), 32'h0);
        chk("b2b_overrun_sticky", 32'(overrun), 32'h1);
        chk("b2b_consume_data", 32'(data_out), 32'h3C);

        // Consume and load on the same edge.
        do_reset();
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("same_edge_pre_valid", 32'(pre_valid), 32'h1);
        chk("same_edge_data", 32'(data_out), 32'h81);
        chk("same_edge_valid", 32'(out_valid), 32'h1);
        chk("same_edge_overrun", 32'(overrun), 32'h0);

        // Reset after four payload bits aborts silently.
        do_reset();
        out_ready = 1'b1;
        data_in   = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            data_in = i[0];
            step();
        end
        chk("mid_busy", 32'(busy), 32'h1);
        rst     = 1'b0;
        data_in = 1'b1;
        step();
        chk("mid_rst_outputs", 32'({data_out, out_valid, busy, parity_err, frame_err, overrun}), 32'h0);
        rst = 1'b1;
        step();
        chk("mid_after_rst_outputs", 32'({data_out, out_valid, busy, parity_err, frame_err, overrun}), 32'h0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("mid_next_valid", 32'(out_valid), 32'h1);
        chk("mid_next_data", 32'(data_out), 32'hA5);
        chk("mid_next_errs", 32'({parity_err, frame_err, overrun}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
